// File: rtl/ahb_slv_if_gen_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the
// ahb_slv_if_gen slave front end.
interface ahb_slv_if_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              sHSEL;
    logic [ADDR_W-1:0] sHADDR;
    logic              sHWRITE;
    logic [2:0]        sHSIZE;
    logic [1:0]        sHTRANS;
    logic [2:0]        sHBURST;
    logic [3:0]        sHPROT;
    logic              sHREADY;
    logic [DATA_W-1:0] sHWDATA;
    logic              sHREADYOUT;
    logic              sHRESP;
    logic [DATA_W-1:0] sHRDATA;

    modport master (
        output sHSEL, sHADDR, sHWRITE, sHSIZE, sHTRANS, sHBURST, sHPROT,
               sHREADY, sHWDATA,
        input  sHREADYOUT, sHRESP, sHRDATA
    );

    modport slave (
        input  sHSEL, sHADDR, sHWRITE, sHSIZE, sHTRANS, sHBURST, sHPROT,
               sHREADY, sHWDATA,
        output sHREADYOUT, sHRESP, sHRDATA
    );
endinterface

// File: rtl/ahb_slv_if_gen.sv
// Pipelined AHB-Lite slave front end: turns AHB address/data phases into a
// single-cycle register-bus strobe (reg_we / reg_re) with byte enables,
// fixed read latency (RD_LAT), extra write wait states (WR_WAIT) and a
// two-cycle ERROR response.
// Optional build macro AHB_SLV_ALIGN_CHK_EN: misaligned accesses take the
// error path with no register strobe. Without it they are aligned down.
// Unsupported sizes always error without touching the register file.
module ahb_slv_if_gen #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_WAIT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ahb_slv_if_gen_if.slave       bus,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic [DATA_W/8-1:0]   reg_wstrb,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_W-1:0]     reg_rdata,
    input  logic                  reg_error
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB_W  = $clog2(STRB_W);

    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, ERR1, ERR2} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [STRB_W-1:0] strb_q, acc_strb;
    logic [DATA_W-1:0] rdata_q;
    logic [LSB_W-1:0]  lsb;
    logic              accept, acc_err, size_ok, take, latch, capture;
    logic              ready, resp;

    // Burst/protection attributes and the SEQ/NONSEQ distinction do not matter here.
    logic unused_ok;
    assign unused_ok = ^{bus.sHBURST, bus.sHPROT, bus.sHTRANS[0]};

    assign accept = bus.sHSEL & bus.sHREADY & bus.sHTRANS[1];

    // Byte enables and access legality, computed from the address phase.
    always_comb begin
        lsb      = bus.sHADDR[LSB_W-1:0];
        acc_strb = '0;
        size_ok  = 1'b1;
        case (bus.sHSIZE)
            3'd0: acc_strb = STRB_W'(1) << lsb;
            3'd1: acc_strb = STRB_W'(3) << (lsb & ~LSB_W'(1));
            3'd2: acc_strb = STRB_W'(15) << (lsb & ~LSB_W'(3));
            3'd3: begin
                if (STRB_W == 8) acc_strb = '1;
                else             size_ok  = 1'b0;
            end
            default: size_ok = 1'b0;
        endcase
        if (!size_ok) acc_strb = '0;
`ifdef AHB_SLV_ALIGN_CHK_EN
        acc_err = !size_ok || (|(lsb & (LSB_W'(32'd1 << bus.sHSIZE) - LSB_W'(1))));
`else
        acc_err = !size_ok;
`endif
    end

    // Next state, bus response and register strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b1;
        resp    = 1'b0;
        reg_we  = 1'b0;
        reg_re  = 1'b0;
        capture = 1'b0;
        take    = 1'b0;
        case (state_q)
            IDLE: take = 1'b1;
            WR: begin
                reg_we = (cnt_q == 2'd0);
                if (cnt_q == 2'd0 && reg_error) begin
                    ready   = 1'b0;
                    state_d = ERR1;
                end else if (cnt_q == 2'(WR_WAIT)) begin
                    take = 1'b1;
                end else begin
                    ready = 1'b0;
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD_WAIT: begin
                ready  = 1'b0;
                reg_re = (cnt_q == 2'd0);
                if (cnt_q == 2'd0 && reg_error) begin
                    state_d = ERR1;
                end else if (cnt_q == 2'(RD_LAT)) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ERR1: begin
                ready   = 1'b0;
                resp    = 1'b1;
                state_d = ERR2;
            end
            ERR2: begin
                resp = 1'b1;
                take = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Data phase is completing: take the next address phase if present.
        latch = take & accept;
        if (take) begin
            state_d = IDLE;
            if (accept) begin
                cnt_d   = 2'd0;
                state_d = acc_err ? ERR1 : (bus.sHWRITE ? WR : RD_WAIT);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address-phase register: address and byte enables of the accepted beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            strb_q <= '0;
        end else if (latch) begin
            addr_q <= bus.sHADDR;
            strb_q <= acc_strb;
        end
    end

    // Read data holds between reads; only a clean read updates it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        rdata_q <= '0;
        else if (capture) rdata_q <= reg_rdata;
    end

    assign reg_addr       = addr_q;
    assign reg_wstrb      = strb_q;
    assign reg_wdata      = bus.sHWDATA;
    assign bus.sHREADYOUT = ready;
    assign bus.sHRESP     = resp;
    assign bus.sHRDATA    = rdata_q;
endmodule

// File: tb/tb_ahb_slv_if_gen.sv
// Bench for ahb_slv_if_gen (DATA_W=32, RD_LAT=2, WR_WAIT=0): reset values,
// a table of isolated transfers, reset mid-read, pipelined write->read,
// unselected/IDLE cycles, then random traffic against a word-array model.
module tb_ahb_slv_if_gen;
    localparam int RD_LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_wstrb;
    logic        reg_we, reg_re, reg_error;
    int          checks = 0;
    int          errors = 0;

    ahb_slv_if_gen_if #(.ADDR_W(32), .DATA_W(32)) ahb ();

    ahb_slv_if_gen #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .WR_WAIT(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(ahb),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_error(reg_error)
    );

    always #5 clk_i = ~clk_i;

    // Single slave on the bus: HREADY follows our own HREADYOUT.
    assign ahb.sHREADY = ahb.sHREADYOUT;

    // Peripheral: 16-word register file, addresses 0xC0-0xFF report an error.
    logic [31:0] rf [16] = '{default: 32'h0};
    assign reg_rdata = rf[reg_addr[5:2]];
    assign reg_error = (reg_addr[7:6] == 2'b11);
    always @(posedge clk_i)
        if (reg_we && !reg_error)
            for (int b = 0; b < 4; b++)
                if (reg_wstrb[b]) rf[reg_addr[5:2]][8*b +: 8] <= reg_wdata[8*b +: 8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_addr(input bit wr, input logic [31:0] a, input logic [2:0] sz);
        ahb.sHSEL = 1'b1; ahb.sHADDR = a; ahb.sHWRITE = wr;
        ahb.sHSIZE = sz; ahb.sHTRANS = 2'b10;
    endtask

    task automatic drive_idle();
        ahb.sHSEL = 1'b0; ahb.sHTRANS = 2'b00;
    endtask

    // One isolated transfer; entered and left at #1 after a rising edge.
    task automatic do_single(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] wd, output int nstb, output logic [31:0] saddr,
                             output logic [3:0] sstrb, output int waits, output bit resp,
                             output bit prev_resp, output logic [31:0] rd, output bit tmo);
        drive_addr(wr, a, sz);
        @(posedge clk_i); #1;
        drive_idle();
        ahb.sHWDATA = wd;
        nstb = 0; waits = 0; tmo = 1'b1; prev_resp = 1'b0; resp = 1'b0;
        saddr = 'x; sstrb = 'x; rd = 'x;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (reg_we || reg_re) begin nstb++; saddr = reg_addr; sstrb = reg_wstrb; end
            if (reg_we && reg_re) nstb += 100;
            if (ahb.sHREADYOUT) begin
                resp = ahb.sHRESP; rd = ahb.sHRDATA; tmo = 1'b0;
                break;
            end
            prev_resp = ahb.sHRESP;
            waits++;
        end
        @(posedge clk_i); #1;
    endtask

    typedef struct {
        bit wr; logic [31:0] addr; logic [2:0] sz; logic [31:0] wd;
        int exp_nstb; logic [3:0] exp_strb; bit exp_err; int exp_waits; logic [31:0] exp_rd;
    } vec_t;

    typedef struct { bit wr; logic [7:0] addr; logic [2:0] size; logic [31:0] wdata; int gap; } rtx_t;

    // Reference model for random traffic: word array + last good read.
    logic [31:0] mem_ref [16];
    logic [31:0] last_rd;
    int          exp_strobes;

    function automatic void model_tx(input rtx_t t, output bit err, output logic [31:0] rd);
        int n, base;
        bit bad;
        bad = (t.size > 3'd2);
`ifdef AHB_SLV_ALIGN_CHK_EN
        if (!bad && (int'(t.addr) % (1 << t.size)) != 0) bad = 1'b1;
`endif
        if (!bad) exp_strobes++;
        err = bad || (t.addr[7:6] == 2'b11);
        rd  = last_rd;
        if (!err) begin
            if (t.wr) begin
                n    = 1 << t.size;
                base = (int'(t.addr) % 4) & ~(n - 1);
                for (int b = base; b < base + n; b++)
                    mem_ref[t.addr[5:2]][8*b +: 8] = t.wdata[8*b +: 8];
            end else begin
                rd      = mem_ref[t.addr[5:2]];
                last_rd = rd;
            end
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [12];
        rtx_t        q [$];
        int          nstb, waits, n_strb, n_both, nxt, cur, gap, budget;
        logic [31:0] saddr, rd;
        logic [3:0]  sstrb;
        bit          resp, presp, tmo, e;

        ahb.sHSEL = 0; ahb.sHADDR = 0; ahb.sHWRITE = 0; ahb.sHSIZE = 0;
        ahb.sHTRANS = 0; ahb.sHBURST = 0; ahb.sHPROT = 0; ahb.sHWDATA = 0;

        // Reset values.
        repeat (3) @(negedge clk_i);
        chk("rst_hreadyout", ahb.sHREADYOUT, 1);
        chk("rst_hresp", ahb.sHRESP, 0);
        chk("rst_hrdata", ahb.sHRDATA, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_re", reg_re, 0);
        chk("rst_wstrb", reg_wstrb, 0);
        chk("rst_addr", reg_addr, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Isolated transfers: wr, addr, size, wdata, strobes, strb, err, waits, rdata.
        vt[0]  = '{1, 32'h11, 3'd0, 32'h0000AB00, 1, 4'b0010, 0, 0, 32'h0};
        vt[1]  = '{1, 32'h22, 3'd1, 32'h12340000, 1, 4'b1100, 0, 0, 32'h0};
        vt[2]  = '{1, 32'h24, 3'd2, 32'hCAFEF00D, 1, 4'b1111, 0, 0, 32'h0};
`ifdef AHB_SLV_ALIGN_CHK_EN
        vt[3]  = '{1, 32'h03, 3'd1, 32'h55660000, 0, 4'b0000, 1, 1, 32'h0};
`else
        vt[3]  = '{1, 32'h03, 3'd1, 32'h55660000, 1, 4'b1100, 0, 0, 32'h0};
`endif
        vt[4]  = '{0, 32'h24, 3'd2, 32'h0, 1, 4'b1111, 0, RD_LAT+1, 32'hCAFEF00D};
        vt[5]  = '{0, 32'h23, 3'd0, 32'h0, 1, 4'b1000, 0, RD_LAT+1, 32'h12340000};
        vt[6]  = '{1, 32'hC0, 3'd2, 32'h11111111, 1, 4'b1111, 1, 2, 32'h0};
        vt[7]  = '{0, 32'hC4, 3'd2, 32'h0, 1, 4'b1111, 1, 2, 32'h12340000};
        vt[8]  = '{1, 32'h08, 3'd3, 32'h77777777, 0, 4'b0000, 1, 1, 32'h0};
        vt[9]  = '{1, 32'h30, 3'd2, 32'hDEADBEEF, 1, 4'b1111, 0, 0, 32'h0};
        vt[10] = '{0, 32'h30, 3'd2, 32'h0, 1, 4'b1111, 0, RD_LAT+1, 32'hDEADBEEF};
        vt[11] = '{0, 32'h10, 3'd0, 32'h0, 1, 4'b0001, 0, RD_LAT+1, 32'h0000AB00};
        for (int i = 0; i < 12; i++) begin
            do_single(vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd, nstb, saddr, sstrb,
                      waits, resp, presp, rd, tmo);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_strobes", i), nstb, vt[i].exp_nstb);
            chk($sformatf("v%0d_resp", i), resp, vt[i].exp_err);
            chk($sformatf("v%0d_waits", i), waits, vt[i].exp_waits);
            if (vt[i].exp_nstb > 0) begin
                chk($sformatf("v%0d_addr", i), saddr, vt[i].addr);
                chk($sformatf("v%0d_wstrb", i), sstrb, vt[i].exp_strb);
            end
            if (vt[i].exp_err) chk($sformatf("v%0d_err1", i), presp, 1);
            if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
        end

        // Reset asserted in the middle of a read wait.
        drive_addr(0, 32'h24, 3'd2);
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        chk("mid_rst_re_seen", reg_re, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1; #1;
        chk("mid_rst_hreadyout", ahb.sHREADYOUT, 1);
        chk("mid_rst_hresp", ahb.sHRESP, 0);
        chk("mid_rst_hrdata", ahb.sHRDATA, 0);
        chk("mid_rst_re", reg_re, 0);
        chk("mid_rst_we", reg_we, 0);
        chk("mid_rst_wstrb", reg_wstrb, 0);
        chk("mid_rst_addr", reg_addr, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        do_single(1, 32'h40, 3'd2, 32'h0BADF00D, nstb, saddr, sstrb, waits, resp, presp, rd, tmo);
        chk("post_rst_wr_strobes", nstb, 1);
        chk("post_rst_wr_resp", resp, 0);
        chk("post_rst_wr_waits", waits, 0);

        // Pipelined write 0x0 then read 0x4 with no idle in between.
        drive_addr(1, 32'h0, 3'd2);
        @(posedge clk_i); #1;
        ahb.sHWDATA = 32'hA5A50F0F;
        drive_addr(0, 32'h4, 3'd2);
        @(negedge clk_i);
        chk("pipe_we", reg_we, 1);
        chk("pipe_we_only", reg_re, 0);
        chk("pipe_we_addr", reg_addr, 32'h0);
        chk("pipe_wr_ready", ahb.sHREADYOUT, 1);
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        chk("pipe_re", reg_re, 1);
        chk("pipe_re_only", reg_we, 0);
        chk("pipe_re_addr", reg_addr, 32'h4);
        nstb = 0; tmo = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ahb.sHREADYOUT) begin tmo = 1'b0; break; end
            @(negedge clk_i);
            nstb += int'(reg_we) + int'(reg_re);
        end
        chk("pipe_rd_timeout", tmo, 0);
        chk("pipe_no_extra_strobe", nstb, 0);
        chk("pipe_rd_resp", ahb.sHRESP, 0);
        chk("pipe_rd_data", ahb.sHRDATA, 32'h0);
        @(posedge clk_i); #1;

        // Unselected NONSEQ and selected IDLE transfers: no access, zero wait.
        nstb = 0; n_both = 0;
        for (int c = 0; c < 4; c++) begin
            ahb.sHADDR = 32'h8; ahb.sHWRITE = 1; ahb.sHSIZE = 2;
            ahb.sHSEL = (c >= 2); ahb.sHTRANS = (c >= 2) ? 2'b00 : 2'b10;
            @(negedge clk_i);
            nstb += int'(reg_we) + int'(reg_re);
            if (!ahb.sHREADYOUT || ahb.sHRESP) n_both++;
            @(posedge clk_i); #1;
        end
        drive_idle();
        chk("unsel_idle_strobes", nstb, 0);
        chk("unsel_idle_okay", n_both, 0);
        @(negedge clk_i);
        chk("unsel_idle_after", int'(reg_we) + int'(reg_re), 0);
        @(posedge clk_i); #1;

        // Random traffic, back-to-back where gap is zero.
        for (int i = 0; i < 16; i++) mem_ref[i] = rf[i];
        last_rd = 32'h0;
        exp_strobes = 0;
        for (int i = 0; i < 200; i++) begin
            rtx_t t;
            t.wr    = 1'($urandom_range(0, 1));
            t.addr  = 8'($urandom_range(0, 255));
            t.size  = 3'($urandom_range(0, 3));
            t.wdata = $urandom;
            t.gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            q.push_back(t);
        end
        nxt = 0; cur = -1; gap = q[0].gap; budget = 0; n_strb = 0; n_both = 0;
        while ((nxt < q.size() || cur >= 0) && budget < 5000) begin
            if (nxt < q.size() && gap == 0) drive_addr(q[nxt].wr, 32'(q[nxt].addr), q[nxt].size);
            else begin ahb.sHSEL = 1'b1; ahb.sHTRANS = 2'b00; end
            if (cur >= 0) ahb.sHWDATA = q[cur].wdata;
            @(negedge clk_i);
            n_strb += int'(reg_we) + int'(reg_re);
            if (reg_we && reg_re) n_both++;
            if (ahb.sHREADYOUT) begin
                if (cur >= 0) begin
                    model_tx(q[cur], e, rd);
                    chk($sformatf("rnd%0d_resp", cur), ahb.sHRESP, e);
                    if (!q[cur].wr) chk($sformatf("rnd%0d_rdata", cur), ahb.sHRDATA, rd);
                    cur = -1;
                end
                if (nxt < q.size() && gap == 0) begin
                    cur = nxt;
                    nxt++;
                    gap = (nxt < q.size()) ? q[nxt].gap : 0;
                end
            end
            if (!(nxt < q.size() && gap == 0) && gap > 0) gap--;
            @(posedge clk_i); #1;
            budget++;
        end
        drive_idle();
        chk("rnd_budget", budget < 5000, 1);
        chk("rnd_strobe_count", n_strb, exp_strobes);
        chk("rnd_we_re_overlap", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
